// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, controller states and half-period helper for the clock divider
package clk_div_pkg;
  localparam int SEL_W = 3;
  localparam int MAX_SEL = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_e;
  function automatic logic [CNT_W-1:0] half_m1(input logic [SEL_W-1:0] sel);
    return CNT_W'((32'd1 << sel) - 32'd1);
  endfunction
endpackage

// File: rtl/clk_div_period_cnt.sv
// clk_div_period_cnt: half-period counter driving the registered divided clock and its tick
module clk_div_period_cnt import clk_div_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic [CNT_W-1:0] half_m1,
  output logic             clk_out,
  output logic             tick,
  output logic             boundary
);
  logic [CNT_W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == half_m1;
  // Last cycle of the low half, independent of run so the controller can use it to halt.
  assign boundary = !clk_out && wrap;
  always_ff @(posedge clk) begin
    if (rst || (!run && !restart)) begin
      cnt <= '0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      clk_out <= 1'b1;
      tick <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      clk_out <= clk_out ^ wrap;
      tick <= boundary;
    end
  end
endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: run/stop and ratio controller that only changes the divided clock on period boundaries
module clk_div_sched import clk_div_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy
);
  state_e state;
  logic [SEL_W-1:0] pend_sel;
  logic stop_flag, acc, legal, boundary, halt, restart, run;
  assign cfg_ready = state == IDLE || state == RUN;
  assign acc = cfg_valid && cfg_ready;
  assign legal = cfg_sel <= SEL_W'(MAX_SEL);
  assign busy = state != IDLE;
  // halt suppresses the 0->1 toggle at the final boundary so no runt high pulse appears
  assign halt = boundary && (state == STOP ? !en : state == PEND && (stop_flag || !en));
  assign restart = (state == IDLE && en) || (state == PEND && boundary && !halt);
  assign run = busy && !halt;
  clk_div_period_cnt u_cnt (
    .clk(clk),
    .rst(rst),
    .run(run),
    .restart(restart),
    .half_m1(half_m1(cur_sel)),
    .clk_out(clk_out),
    .tick(tick),
    .boundary(boundary)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_sel <= '0;
      pend_sel <= '0;
      stop_flag <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= acc && !legal;
      unique case (state)
        IDLE: begin
          if (acc && legal) cur_sel <= cfg_sel;
          if (en) state <= RUN;
        end
        RUN: begin
          if (acc && legal) begin
            pend_sel <= cfg_sel;
            stop_flag <= !en;
            state <= PEND;
          end else if (!en) state <= STOP;
        end
        PEND: begin
          stop_flag <= stop_flag || !en;
          if (boundary) begin
            cur_sel <= pend_sel;
            state <= halt ? IDLE : RUN;
          end
        end
        STOP: begin
          if (en) state <= RUN;
          else if (boundary) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed checks of start, ratio change, illegal config, stop and reset behaviour
module tb_clk_div_sched;
  import clk_div_pkg::*;
  logic clk = 0, rst = 1, en = 0, cfg_valid = 0;
  logic [SEL_W-1:0] cfg_sel = '0;
  logic cfg_ready, cfg_err, clk_out, tick, busy;
  logic [SEL_W-1:0] cur_sel;
  int errors = 0, checks = 0;
  clk_div_sched dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_sel(cfg_sel),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick),
    .cur_sel(cur_sel),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input int co, input int tk, input int cs, input int rdy, input int bz);
    check({tag, "/clk_out"}, int'(clk_out), co);
    check({tag, "/tick"}, int'(tick), tk);
    check({tag, "/cur_sel"}, int'(cur_sel), cs);
    check({tag, "/cfg_ready"}, int'(cfg_ready), rdy);
    check({tag, "/busy"}, int'(busy), bz);
  endtask
  initial begin
    repeat (3) cyc();
    expect_out("rst", 0, 0, 0, 1, 0);
    check("rst/cfg_err", int'(cfg_err), 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_out("idle", 0, 0, 0, 1, 0);
    end
    cfg_valid = 1; cfg_sel = 0;
    cyc();
    cfg_valid = 0;
    check("idle_cfg/cfg_err", int'(cfg_err), 0);
    en = 1;
    cyc();
    expect_out("start", 1, 1, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      expect_out("div2", int'(i % 2 == 0), int'(i % 2 == 0), 0, 1, 1);
    end
    cfg_valid = 1; cfg_sel = 2;
    cyc();
    cfg_valid = 0;
    expect_out("pend2", 0, 0, 0, 0, 1);
    cyc();
    expect_out("swap4", 1, 1, 2, 1, 1);
    for (int i = 1; i <= 16; i++) begin
      cfg_valid = (i == 1); cfg_sel = 6;
      cyc();
      expect_out("div8", int'(i % 8 < 4), int'(i % 8 == 0), 2, 1, 1);
      check("div8/cfg_err", int'(cfg_err), int'(i == 1));
    end
    cfg_valid = 1; cfg_sel = 3;
    cyc();
    cfg_valid = 0;
    expect_out("pend8", 1, 0, 2, 0, 1);
    for (int i = 18; i <= 23; i++) begin
      cyc();
      expect_out("pend8", int'(i % 8 < 4), 0, 2, 0, 1);
    end
    cyc();
    expect_out("swap16", 1, 1, 3, 1, 1);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      expect_out("stop16", int'(k < 8), 0, 3, int'(k <= 2 || k == 16), int'(k < 16));
      if (k == 2) en = 0;
    end
    cyc();
    expect_out("idle16", 0, 0, 3, 1, 0);
    en = 1;
    cyc();
    expect_out("rerun", 1, 1, 3, 1, 1);
    en = 0; cfg_valid = 1; cfg_sel = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      cfg_valid = 0;
      expect_out("pstop", int'(k < 8), 0, k < 16 ? 3 : 1, int'(k == 16), int'(k < 16));
    end
    en = 1;
    cyc();
    expect_out("run4", 1, 1, 1, 1, 1);
    cfg_valid = 1; cfg_sel = 4;
    cyc();
    cfg_valid = 0;
    expect_out("pend_rst", 1, 0, 1, 0, 1);
    rst = 1; en = 0;
    cyc();
    expect_out("rst_mid", 0, 0, 0, 1, 0);
    check("rst_mid/cfg_err", int'(cfg_err), 0);
    rst = 0;
    cyc();
    expect_out("post_rst", 0, 0, 0, 1, 0);
    en = 1;
    cyc();
    expect_out("post_run", 1, 1, 0, 1, 1);
    cyc();
    expect_out("post_div2", 0, 0, 0, 1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
